rf_wb_arbiter: RTL

- Shares the single register-file write port (WE_RF/RW_RF/DW_RF) between two write-back requesters: ALU (port 0) and load/memory unit (port 1).
- Fixed priority to memory, with an anti-starvation counter for the ALU.
- Registered outputs drive the register file directly.
- Sits between the execute/memory stages and Register_File in the RISC-V core.

---
 rtl/rf_wb_arbiter_pkg.sv | 19 +
 rtl/rf_wb_arbiter_scoreboard.sv | 38 +++
 rtl/rf_wb_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   REG_ADDR_W / XLEN / NUM_REGS : register-file geometry
//   REQ_ALU / REQ_MEM            : bit positions of each requester in the grant vector
//   WAIT_W                       : width of the ALU anti-starvation counter
package rf_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MEM = 1;

  localparam int unsigned WAIT_W = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// rf_scoreboard: busy bit per architectural register plus the read-side stall lookup.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   set_v_i / set_rd_i   : mark a destination busy when an instruction issues
//   clr_v_i / clr_rd_i   : clear the register whose write-back was granted
//   ra_i / rb_i          : source registers being read
//   stall_o              : either source has a pending write
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      set_v_i,
  input  reg_addr_t set_rd_i,
  input  logic      clr_v_i,
  input  reg_addr_t clr_rd_i,
  input  reg_addr_t ra_i,
  input  reg_addr_t rb_i,
  output logic      stall_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_v_i) busy_d[clr_rd_i] = 1'b0;
    // Applied after the clear so a same-edge re-issue keeps the register busy.
    if (set_v_i) busy_d[set_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign stall_o = rst_ni & (busy_q[ra_i] | busy_q[rb_i]);

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the ALU and the
// load/memory unit. Memory has fixed priority; the ALU is forced through after it has
// been denied MAX_WAIT consecutive cycles. Write port outputs are registered.
//   CLK, RES                   : clock, synchronous active-low reset
//   ALU_V/ALU_RD/ALU_D/ALU_RDY : ALU write-back request and combinational accept
//   MEM_V/MEM_RD/MEM_D/MEM_RDY : memory write-back request and combinational accept
//   WE_RF/RW_RF/DW_RF          : registered register-file write port
//   CONF_CNT                   : saturating count of cycles with both requests valid
//   ISSUE_V/ISSUE_RD/RA_Q/RB_Q : scoreboard issue and source lookups
//   STALL                      : a source register has a pending write
// Build option: define RF_SCOREBOARD_EN to include the busy-register scoreboard;
// otherwise STALL is tied low and the scoreboard inputs are ignored.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             ALU_V,
  input  logic [4:0]       ALU_RD,
  input  logic [31:0]      ALU_D,
  output logic             ALU_RDY,
  input  logic             MEM_V,
  input  logic [4:0]       MEM_RD,
  input  logic [31:0]      MEM_D,
  output logic             MEM_RDY,
  output logic             WE_RF,
  output logic [4:0]       RW_RF,
  output logic [31:0]      DW_RF,
  output logic [CNT_W-1:0] CONF_CNT,
  input  logic             ISSUE_V,
  input  logic [4:0]       ISSUE_RD,
  input  logic [4:0]       RA_Q,
  input  logic [4:0]       RB_Q,
  output logic             STALL
);

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  logic [1:0]        gnt;
  reg_addr_t         win_rd;
  xlen_t             win_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              we_q, we_d;
  reg_addr_t         rw_q, rw_d;
  xlen_t             dw_q, dw_d;
  logic [CNT_W-1:0]  conf_q, conf_d;

  // One-hot grant, suppressed entirely while in reset.
  always_comb begin
    gnt = '0;
    if (RES) begin
      if (ALU_V && MEM_V) begin
        if (wait_q == MaxWait) gnt[REQ_ALU] = 1'b1;
        else                   gnt[REQ_MEM] = 1'b1;
      end else begin
        gnt[REQ_ALU] = ALU_V;
        gnt[REQ_MEM] = MEM_V;
      end
    end
  end

  assign ALU_RDY = gnt[REQ_ALU];
  assign MEM_RDY = gnt[REQ_MEM];
  assign win_rd  = gnt[REQ_ALU] ? ALU_RD : MEM_RD;
  assign win_d   = gnt[REQ_ALU] ? ALU_D  : MEM_D;

  always_comb begin
    wait_d = wait_q;
    if (!ALU_V || gnt[REQ_ALU]) wait_d = '0;
    else if (wait_q != MaxWait) wait_d = wait_q + 1'b1;

    // x0 writes complete the handshake but never reach the register file.
    we_d = (|gnt) && (win_rd != '0);
    rw_d = we_d ? win_rd : rw_q;
    dw_d = we_d ? win_d  : dw_q;

    conf_d = conf_q;
    if (ALU_V && MEM_V && !(&conf_q)) conf_d = conf_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RES) begin
      wait_q <= '0;
      we_q   <= 1'b0;
      rw_q   <= '0;
      dw_q   <= '0;
      conf_q <= '0;
    end else begin
      wait_q <= wait_d;
      we_q   <= we_d;
      rw_q   <= rw_d;
      dw_q   <= dw_d;
      conf_q <= conf_d;
    end
  end

  assign WE_RF    = we_q;
  assign RW_RF    = rw_q;
  assign DW_RF    = dw_q;
  assign CONF_CNT = conf_q;

`ifdef RF_SCOREBOARD_EN
  rf_scoreboard u_scoreboard (
    .clk_i    (CLK),
    .rst_ni   (RES),
    .set_v_i  (ISSUE_V && (ISSUE_RD != '0)),
    .set_rd_i (ISSUE_RD),
    .clr_v_i  (|gnt),
    .clr_rd_i (win_rd),
    .ra_i     (RA_Q),
    .rb_i     (RB_Q),
    .stall_o  (STALL)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{ISSUE_V, ISSUE_RD, RA_Q, RB_Q};
  assign STALL     = 1'b0;
`endif

endmodule
